// File: rtl/esp32_osd_cmd_if.sv
// SPI receive handshake and OSD buffer write bus for the ESP32 OSD command writer.
interface esp32_osd_cmd_if;
  logic        spi_frame;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;

  modport master (
    output spi_frame, rx_byte, rx_valid,
    input  rx_ready, wr_addr, wr_data, wr_en
  );

  modport slave (
    input  spi_frame, rx_byte, rx_valid,
    output rx_ready, wr_addr, wr_data, wr_en
  );
endinterface

// File: rtl/esp32_osd_cmd_writer.sv
// Decodes SPI command frames into OSD buffer writes, overlay control and clear.
// Optional CLEAR command (opcode 0x02) is built only when ESP32_OSD_CLEAR_EN is defined.
module esp32_osd_cmd_writer (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  esp32_osd_cmd_if.slave        bus,
  output logic                  osd_enable,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

`ifdef ESP32_OSD_CLEAR_EN
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, CTRL, DISCARD, CLEAR} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, CTRL, DISCARD} state_t;
`endif

  state_t      state, next;
  logic [11:0] ptr;
  logic        accept;
  logic        known_op;

  always_comb begin
    accept   = bus.spi_frame && bus.rx_valid && bus.rx_ready;
`ifdef ESP32_OSD_CLEAR_EN
    known_op = (bus.rx_byte == 8'h01) || (bus.rx_byte == 8'h02) || (bus.rx_byte == 8'h03);
    busy     = (state == CLEAR);
`else
    known_op = (bus.rx_byte == 8'h01) || (bus.rx_byte == 8'h03);
    busy     = 1'b0;
`endif
    bus.rx_ready = ~busy;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.rx_byte)
            8'h01:   next = ADDR_HI;
`ifdef ESP32_OSD_CLEAR_EN
            8'h02:   next = CLEAR;
`endif
            8'h03:   next = CTRL;
            default: next = DISCARD;
          endcase
        end
      end
      ADDR_HI: if (accept) next = ADDR_LO;
      ADDR_LO: if (accept) next = DATA;
      CTRL:    if (accept) next = DISCARD;
`ifdef ESP32_OSD_CLEAR_EN
      CLEAR:   if (bus.wr_addr == 12'hFFF) next = IDLE;
`endif
      default: next = state;
    endcase
    // Frame end aborts everything except a clear, which always completes.
`ifdef ESP32_OSD_CLEAR_EN
    if (!bus.spi_frame && state != CLEAR) next = IDLE;
`else
    if (!bus.spi_frame) next = IDLE;
`endif
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.wr_en   <= 1'b0;
      osd_enable  <= 1'b0;
      err_cnt     <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!known_op && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef ESP32_OSD_CLEAR_EN
            // First clear write is issued on the cycle CLEAR is entered.
            if (bus.rx_byte == 8'h02) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= '0;
              bus.wr_data <= 8'h20;
            end
`endif
          end
        end
        ADDR_HI: if (accept) ptr[11:8] <= bus.rx_byte[3:0];
        ADDR_LO: if (accept) ptr[7:0]  <= bus.rx_byte;
        DATA: begin
          if (accept) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= ptr;
            bus.wr_data <= bus.rx_byte;
            ptr         <= ptr + 12'd1;
          end
        end
        CTRL: if (accept) osd_enable <= bus.rx_byte[0];
`ifdef ESP32_OSD_CLEAR_EN
        CLEAR: begin
          if (bus.wr_addr != 12'hFFF) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= bus.wr_addr + 12'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/esp32_osd_cmd_writer.md
ESP32_OSD_CMD_WRITER -- requirements
Module: esp32_osd_cmd_writer

Interface
REQ-001 SHALL have port clk_sys, input, 1: system clock (50 MHz), sole clock of the block.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have port spi_frame, input, 1: SPI chip-select active, already synchronised to clk_sys; high = frame in progress.
REQ-004 SHALL have port rx_byte, input, 8: received SPI byte.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle strobe, rx_byte valid.
REQ-006 SHALL have port rx_ready, output, 1: block can accept a byte.
REQ-007 SHALL have port wr_addr, output, 12: OSD buffer byte address.
REQ-008 SHALL have port wr_data, output, 8: OSD buffer write data.
REQ-009 SHALL have port wr_en, output, 1: OSD buffer write strobe.
REQ-010 SHALL have port osd_enable, output, 1: OSD overlay visible.
REQ-011 SHALL have port busy, output, 1: clear operation in progress.
REQ-012 SHALL have port err_cnt, output, 8: count of unknown-opcode frames, saturating at 0xFF.

Function
REQ-013 SHALL accept a byte only on a cycle with rx_valid=1 and rx_ready=1; a byte with rx_ready=0 is dropped.
REQ-014 SHALL implement states IDLE, ADDR_HI, ADDR_LO, DATA, CTRL, CLEAR, DISCARD.
REQ-015 SHALL, in IDLE, treat the first accepted byte of a frame as opcode: 0x01 -> ADDR_HI, 0x02 -> CLEAR, 0x03 -> CTRL, any other value -> DISCARD with err_cnt+1.
REQ-016 SHALL, in ADDR_HI, latch rx_byte[3:0] as address bits [11:8] and go to ADDR_LO; ADDR_LO latches bits [7:0] and goes to DATA.
REQ-017 SHALL, in DATA, issue one write per accepted byte: wr_en=1 exactly one cycle after acceptance, wr_data=byte, wr_addr=current pointer; pointer then increments.
REQ-018 SHALL wrap the pointer from 0xFFF to 0x000 without error.
REQ-019 SHALL, in CTRL, set osd_enable=rx_byte[0] on the first accepted byte, then go to DISCARD.
REQ-020 SHALL, in CLEAR, starting the cycle after opcode acceptance, drive wr_en=1 for 4096 consecutive cycles, wr_addr 0x000..0xFFF ascending, wr_data=0x20, then return to IDLE.
REQ-021 SHALL hold busy=1 and rx_ready=0 for the whole CLEAR state; rx_ready=1 in every other state.
REQ-022 SHALL ignore all bytes in DISCARD.
REQ-023 SHALL return to IDLE on the cycle after spi_frame falls, from any state except CLEAR; CLEAR always runs to completion regardless of spi_frame.
REQ-024 SHALL ignore rx_valid while spi_frame=0.
REQ-025 SHALL, when spi_frame falls on the same cycle as an accepted DATA byte, still perform that write.
REQ-026 SHALL keep wr_en=0 on every cycle not specified above.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, pointer=0x000, wr_addr=0x000, wr_data=0x00, wr_en=0, osd_enable=0, busy=0, err_cnt=0x00, rx_ready=1.
REQ-028 SHALL abort a CLEAR in progress on reset; no further writes occur after rst_n falls.

Configuration
REQ-029 SHALL compile the CLEAR command only when macro ESP32_OSD_CLEAR_EN is defined.
REQ-030 SHALL, without ESP32_OSD_CLEAR_EN, treat opcode 0x02 as unknown (DISCARD, err_cnt+1), hold busy=0 and rx_ready=1 permanently, and contain no CLEAR state logic.

Verification
REQ-031 Write: frame 01 00 20 41 42 -> writes (0x020,0x41), (0x021,0x42), each one cycle after its byte.
REQ-032 Wrap: frame 01 0F FF AA BB -> writes (0xFFF,0xAA), (0x000,0xBB).
REQ-033 Clear (macro defined): frame 02 -> 4096 consecutive writes of 0x20 at 0x000..0xFFF, busy=1 and rx_ready=0 throughout, bytes sent meanwhile dropped; without the macro -> no writes, err_cnt=1.
REQ-034 Control/unknown: frame 03 01 -> osd_enable=1; frame 7E 01 02 -> no writes, err_cnt+1, osd_enable unchanged.
REQ-035 Frame abort: frame 01 00 10 55 with spi_frame dropping after 0x55, then new frame 03 00 -> one write (0x010,0x55), osd_enable=0, no write from 03/00.
REQ-036 Reset mid-clear: rst_n low at clear cycle 100 -> wr_en=0 immediately, all outputs at reset values, next frame decodes from IDLE.
